serial_subtractor: RTL and testbench

Bit-serial two's-complement subtractor computing Diff = A − B − Bin, one bit per clock, LSB first. It uses a single full-subtractor cell and a registered borrow flip-flop. It is the inverse-operation companion to the team's combinational full-adder netlist, and serves as a small sequential benchmark circuit in the same netlist library. Operands are loaded by a start pulse, and the result is presented with a one-cycle done strobe.

---
 rtl/serial_subtractor_if.sv | 14 +
 rtl/serial_subtractor.sv | 62 ++++++
 tb/tb_serial_subtractor.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: operand load and result bundle for the bit-serial subtractor
interface serial_subtractor_if #(parameter int WIDTH = 8);
  logic start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic bin;
  logic busy;
  logic done;
  logic [WIDTH-1:0] diff;
  logic bout;
  logic v;
  modport master (output start, a, b, bin, input busy, done, diff, bout, v);
  modport slave (input start, a, b, bin, output busy, done, diff, bout, v);
endinterface

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b - bin, LSB first, one full-subtractor cell and a borrow flop
module serial_subtractor #(parameter int WIDTH = 8) (
  input logic clk,
  input logic rst_n,
  serial_subtractor_if.slave s
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] sa, sb, sr;
  logic [CW-1:0] cnt;
  logic borrow, d, nb;
  assign d = sa[0] ^ sb[0] ^ borrow;
  assign nb = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & borrow);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sa <= '0;
      sb <= '0;
      sr <= '0;
      cnt <= '0;
      borrow <= 1'b0;
      s.busy <= 1'b0;
      s.done <= 1'b0;
      s.diff <= '0;
      s.bout <= 1'b0;
      s.v <= 1'b0;
    end else begin
      case (state)
        IDLE: if (s.start) begin
          sa <= s.a;
          sb <= s.b;
          borrow <= s.bin;
          cnt <= '0;
          sr <= '0;
          state <= RUN;
          s.busy <= 1'b1;
        end
        RUN: begin
          sa <= sa >> 1;
          sb <= sb >> 1;
          sr <= {d, sr[WIDTH-1:1]};
          borrow <= nb;
          cnt <= cnt + 1'b1;
          // borrow here is the borrow into the MSB on the final bit
          if (cnt == CW'(WIDTH - 1)) begin
            state <= DONE;
            s.done <= 1'b1;
            s.diff <= {d, sr[WIDTH-1:1]};
            s.bout <= nb;
            s.v <= borrow ^ nb;
          end
        end
        default: begin
          state <= IDLE;
          s.done <= 1'b0;
          s.busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed and random checks of serial_subtractor against an arithmetic model
module tb_serial_subtractor;
  localparam int W = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int errors = 0;
  int checks = 0;
  logic [W-1:0] prev;
  always #5 clk = ~clk;
  serial_subtractor_if #(.WIDTH(W)) bus ();
  serial_subtractor #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .s(bus));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // returns {bout, v, diff}
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    int ur, sr;
    logic [W-1:0] dv;
    ur = int'(a) - int'(b) - int'(bin);
    sr = int'($signed(a)) - int'($signed(b)) - int'(bin);
    dv = ur[W-1:0];
    return {ur < 0, (sr < -(1 << (W - 1))) || (sr > (1 << (W - 1)) - 1), dv};
  endfunction

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin, input bit noisy, input string tag);
    logic [W+1:0] m;
    int k;
    m = model(a, b, bin);
    @(negedge clk);
    prev = bus.diff;
    bus.start = 1'b1;
    bus.a = a;
    bus.b = b;
    bus.bin = bin;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
    k = 0;
    while (!bus.done && k < 20) begin
      if (noisy) begin
        bus.start = 1'b1;
        bus.a = W'($urandom);
        bus.b = W'($urandom);
        bus.bin = 1'($urandom);
      end
      @(posedge clk);
      #1;
      k++;
      if (!bus.done) chk({tag, "_hold"}, 32'(bus.diff), 32'(prev));
    end
    bus.start = 1'b0;
    chk({tag, "_lat"}, 32'(k), 32'(W));
    chk({tag, "_diff"}, 32'(bus.diff), 32'(m[W-1:0]));
    chk({tag, "_bout"}, 32'(bus.bout), 32'(m[W+1]));
    chk({tag, "_v"}, 32'(bus.v), 32'(m[W]));
    @(posedge clk);
    #1;
    chk({tag, "_done1"}, 32'(bus.done), 32'd0);
    chk({tag, "_idle"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int k;
    logic [W-1:0] ra, rb;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.bin = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_diff", 32'(bus.diff), 32'd0);
    chk("rst_bout", 32'(bus.bout), 32'd0);
    chk("rst_v", 32'(bus.v), 32'd0);
    rst_n = 1'b1;
    run_op(8'h5A, 8'h3C, 1'b0, 1'b0, "d5a");
    run_op(8'h00, 8'h01, 1'b0, 1'b0, "d00");
    run_op(8'h80, 8'h01, 1'b0, 1'b0, "d80");
    run_op(8'h10, 8'h0F, 1'b1, 1'b0, "d10");
    run_op(8'h00, 8'hFF, 1'b1, 1'b0, "dff");
    run_op(8'hC3, 8'h47, 1'b1, 1'b1, "noisy");
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = 8'h33;
    bus.b = 8'h11;
    bus.bin = 1'b0;
    @(posedge clk);
    #1;
    k = 0;
    while (!bus.done && k < 20) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("held_lat1", 32'(k), 32'(W));
    chk("held_diff1", 32'(bus.diff), 32'h22);
    @(posedge clk);
    #1;
    k++;
    while (!bus.done && k < 40) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("held_lat2", 32'(k), 32'(2 * W + 2));
    chk("held_diff2", 32'(bus.diff), 32'h22);
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    run_op(8'h5A, 8'h3C, 1'b0, 1'b0, "pre_rst");
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = 8'h77;
    bus.b = 8'h11;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_busy", 32'(bus.busy), 32'd0);
    chk("mid_done", 32'(bus.done), 32'd0);
    chk("mid_diff", 32'(bus.diff), 32'd0);
    chk("mid_bout", 32'(bus.bout), 32'd0);
    chk("mid_v", 32'(bus.v), 32'd0);
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      chk("mid_nodone", 32'(bus.done), 32'd0);
      if (i == 2) rst_n = 1'b1;
    end
    run_op(8'h77, 8'h11, 1'b0, 1'b0, "post_rst");
    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      run_op(ra, rb, 1'($urandom), 1'b0, "rand");
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
